// File: rtl/cpu_controller.sv
// Phase-sequencing control unit for the 8-bit accumulator CPU: walks the
// 8-phase instruction cycle and decodes per-phase register/memory enables.
module cpu_controller (
    input  logic       clk,
    input  logic       rst_,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_wr
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_t     phase_reg;
    phase_t     phase_next;
    logic       halted_reg;
    logic       halted_next;
    logic [2:0] phase_inc;
    logic       is_aluop;

    assign phase_inc = phase_reg + 3'd1;
    assign is_aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                       (opcode == OP_XOR) || (opcode == OP_LDA);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_reg  <= INST_ADDR;
            halted_reg <= 1'b0;
        end else begin
            phase_reg  <= phase_next;
            halted_reg <= halted_next;
        end
    end

    // Once halted the phase freezes at OP_ADDR; only reset leaves this state.
    always_comb begin
        phase_next  = phase_reg;
        halted_next = halted_reg;
        if (!halted_reg) begin
            if ((phase_reg == OP_ADDR) && (opcode == OP_HLT)) begin
                halted_next = 1'b1;
            end else begin
                phase_next = phase_t'(phase_inc);
            end
        end
    end

    // Phases 0-3 never look at opcode, so an unsettled IR cannot disturb them.
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        if (halted_reg) begin
            halt = 1'b1;
        end else begin
            case (phase_reg)
                INST_ADDR: begin
                end
                INST_FETCH: begin
                    mem_rd = 1'b1;
                end
                INST_LOAD: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    halt   = (opcode == OP_HLT);
                    inc_pc = (opcode != OP_HLT);
                end
                OP_FETCH: begin
                    mem_rd = is_aluop;
                end
                ALU_OP: begin
                    mem_rd  = is_aluop;
                    load_ac = is_aluop;
                    inc_pc  = (opcode == OP_SKZ) && zero;
                    load_pc = (opcode == OP_JMP);
                end
                STORE: begin
                    mem_rd  = is_aluop;
                    load_ac = is_aluop;
                    inc_pc  = (opcode == OP_JMP);
                    load_pc = (opcode == OP_JMP);
                    mem_wr  = (opcode == OP_STO);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed opcode scenarios plus
// randomized instruction streams compared against a phase-table model.
module tb_cpu_controller;

    logic       clk;
    logic       rst_;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
    logic [6:0] obs;

    int tests_run;
    int tests_failed;
    int model_phase;
    bit model_halted;

    cpu_controller dut (
        .clk     (clk),
        .rst_    (rst_),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (mem_rd),
        .load_ir (load_ir),
        .halt    (halt),
        .inc_pc  (inc_pc),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .mem_wr  (mem_wr)
    );

    assign obs = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {mem_rd,load_ir,halt,inc_pc,load_ac,load_pc,mem_wr} for a phase.
    function automatic logic [6:0] expect_out(input int ph, input bit hl,
                                              input logic [2:0] op, input logic z);
        bit aluop, rd, ir, hlt, inc, ac, pc, wr;
        if (hl) return 7'b0010000;
        rd = (ph >= 1 && ph <= 3);
        ir = (ph == 2 || ph == 3);
        hlt = 0; inc = 0; ac = 0; pc = 0; wr = 0;
        if (ph >= 4) begin
            aluop = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
            if (ph == 4) begin
                hlt = (op == 3'd0);
                inc = !hlt;
            end else begin
                rd  = aluop;
                ac  = (ph >= 6) && aluop;
                pc  = (ph >= 6) && (op == 3'd7);
                inc = (ph == 6 && op == 3'd1 && z === 1'b1) || (ph == 7 && op == 3'd7);
                wr  = (ph == 7 && op == 3'd6);
            end
        end
        return {rd, ir, hlt, inc, ac, pc, wr};
    endfunction

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (!model_halted) begin
            if (model_phase == 4 && opcode === 3'd0) model_halted = 1'b1;
            else model_phase = (model_phase + 1) % 8;
        end
        #1;
    endtask

    // Opcode is X while the instruction is still being fetched.
    task automatic drive(input logic [2:0] op, input logic z);
        opcode = (!model_halted && model_phase < 2) ? 3'bxxx : op;
        zero   = z;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        model_phase = 0;
        model_halted = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        rst_ = 1'b0; opcode = 3'd2; zero = 1'b0;
        #12;
        tests_run++;
        if (obs !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_low got=%b exp=%b", obs, 7'b0);
        end
        release_reset();
        tests_run++;
        if (obs !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_first_cycle got=%b exp=%b", obs, 7'b0);
        end
        for (int c = 0; c < 6; c++) begin
            drive(3'd2, 1'b0);
            tick();
        end
        drive(3'd2, 1'b0);
        exp = expect_out(model_phase, model_halted, 3'd2, 1'b0);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL reset_pre_aluop ph=%0d got=%b exp=%b", model_phase, obs, exp);
        end
        rst_ = 1'b0;
        #1;
        tests_run++;
        if (obs !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_async_mid got=%b exp=%b", obs, 7'b0);
        end
        release_reset();
        for (int c = 0; c < 8; c++) begin
            drive(3'd2, 1'b1);
            exp = expect_out(model_phase, model_halted, 3'd2, 1'b1);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL reset_walk ph=%0d got=%b exp=%b", model_phase, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_lda();
        logic [7:0] m_rd, m_ir, m_inc, m_ac, m_pc, m_wr;
        logic [6:0] exp;
        m_rd = 0; m_ir = 0; m_inc = 0; m_ac = 0; m_pc = 0; m_wr = 0;
        for (int c = 0; c < 8; c++) begin
            drive(3'd5, 1'b0);
            exp = expect_out(model_phase, model_halted, 3'd5, 1'b0);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL lda_phase ph=%0d got=%b exp=%b", model_phase, obs, exp);
            end
            m_rd[model_phase] = mem_rd; m_ir[model_phase] = load_ir;
            m_inc[model_phase] = inc_pc; m_ac[model_phase] = load_ac;
            m_pc[model_phase] = load_pc; m_wr[model_phase] = mem_wr;
            tick();
        end
        tests_run++;
        if ({m_rd, m_ir, m_inc, m_ac, m_pc, m_wr} !==
            {8'b11101110, 8'b00001100, 8'b00010000, 8'b11000000, 8'h00, 8'h00}) begin
            tests_failed++;
            $display("FAIL lda_masks rd=%b ir=%b inc=%b ac=%b pc=%b wr=%b exp rd=11101110 ir=00001100 inc=00010000 ac=11000000 pc=0 wr=0",
                     m_rd, m_ir, m_inc, m_ac, m_pc, m_wr);
        end
    endtask

    task automatic test_skz();
        logic [7:0] m_inc;
        logic [6:0] exp;
        logic       z;
        for (int k = 0; k < 2; k++) begin
            m_inc = 0;
            for (int c = 0; c < 8; c++) begin
                z = (model_phase == 6) ? (k == 0) : 1'($urandom_range(0, 1));
                drive(3'd1, z);
                exp = expect_out(model_phase, model_halted, 3'd1, z);
                tests_run++;
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL skz_phase k=%0d ph=%0d got=%b exp=%b", k, model_phase, obs, exp);
                end
                m_inc[model_phase] = inc_pc;
                tick();
            end
            tests_run++;
            if (m_inc !== ((k == 0) ? 8'b01010000 : 8'b00010000)) begin
                tests_failed++;
                $display("FAIL skz_inc_mask k=%0d got=%b exp=%b", k, m_inc,
                         (k == 0) ? 8'b01010000 : 8'b00010000);
            end
        end
    endtask

    task automatic test_jmp_sto();
        logic [7:0] m_pc, m_inc, m_ac, m_wr, m_rd;
        logic [6:0] exp;
        for (int k = 0; k < 2; k++) begin
            m_pc = 0; m_inc = 0; m_ac = 0; m_wr = 0; m_rd = 0;
            for (int c = 0; c < 8; c++) begin
                drive((k == 0) ? 3'd7 : 3'd6, 1'b1);
                exp = expect_out(model_phase, model_halted, (k == 0) ? 3'd7 : 3'd6, 1'b1);
                tests_run++;
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL jmp_sto_phase k=%0d ph=%0d got=%b exp=%b", k, model_phase, obs, exp);
                end
                m_pc[model_phase] = load_pc; m_inc[model_phase] = inc_pc;
                m_ac[model_phase] = load_ac; m_wr[model_phase] = mem_wr;
                m_rd[model_phase] = mem_rd;
                tick();
            end
            tests_run++;
            if (k == 0 && {m_pc, m_inc, m_ac} !== {8'b11000000, 8'b10010000, 8'h00}) begin
                tests_failed++;
                $display("FAIL jmp_masks pc=%b inc=%b ac=%b exp pc=11000000 inc=10010000 ac=0",
                         m_pc, m_inc, m_ac);
            end else if (k == 1 && {m_wr, m_rd} !== {8'b10000000, 8'b00001110}) begin
                tests_failed++;
                $display("FAIL sto_masks wr=%b rd=%b exp wr=10000000 rd=00001110", m_wr, m_rd);
            end
        end
    endtask

    task automatic test_halt();
        logic [6:0] exp;
        logic [2:0] op;
        for (int c = 0; c < 5; c++) begin
            drive(3'd0, 1'b0);
            exp = expect_out(model_phase, model_halted, 3'd0, 1'b0);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL halt_entry ph=%0d got=%b exp=%b", model_phase, obs, exp);
            end
            if (c < 4) tick();
        end
        tick();
        for (int c = 0; c < 20; c++) begin
            op = ($urandom_range(0, 3) == 0) ? 3'bxxx : 3'($urandom_range(0, 7));
            drive(op, 1'($urandom_range(0, 1)));
            tests_run++;
            if (obs !== 7'b0010000) begin
                tests_failed++;
                $display("FAIL halt_hold c=%0d got=%b exp=%b", c, obs, 7'b0010000);
            end
            tick();
        end
        rst_ = 1'b0;
        #1;
        tests_run++;
        if (obs !== 7'b0) begin
            tests_failed++;
            $display("FAIL halt_reset got=%b exp=%b", obs, 7'b0);
        end
        release_reset();
        for (int c = 0; c < 8; c++) begin
            drive(3'd3, 1'b0);
            exp = expect_out(model_phase, model_halted, 3'd3, 1'b0);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL halt_recover ph=%0d got=%b exp=%b", model_phase, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [6:0] exp;
        logic [2:0] op;
        logic       z;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(1, 7));
            for (int c = 0; c < 8; c++) begin
                z = 1'($urandom_range(0, 1));
                drive(op, z);
                exp = expect_out(model_phase, model_halted, op, z);
                tests_run++;
                if (obs !== exp || (mem_rd && mem_wr)) begin
                    tests_failed++;
                    $display("FAIL random op=%0d ph=%0d got=%b exp=%b", op, model_phase, obs, exp);
                end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        logic [2:0] op;
        int         cut;
        for (int n = 0; n < 6; n++) begin
            op  = 3'($urandom_range(1, 7));
            cut = $urandom_range(1, 7);
            for (int c = 0; c < cut; c++) begin
                drive(op, 1'b1);
                exp = expect_out(model_phase, model_halted, op, 1'b1);
                tests_run++;
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL b2b op=%0d ph=%0d got=%b exp=%b", op, model_phase, obs, exp);
                end
                tick();
            end
            drive(op, 1'b1);
            rst_ = 1'b0;
            #1;
            tests_run++;
            if (obs !== 7'b0) begin
                tests_failed++;
                $display("FAIL b2b_reset ph=%0d got=%b exp=%b", model_phase, obs, 7'b0);
            end
            release_reset();
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        model_phase = 0;
        model_halted = 1'b0;
        test_reset();
        test_lda();
        test_skz();
        test_jmp_sto();
        test_random();
        test_back_to_back();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Phase-sequencing control unit for the 8-bit accumulator CPU datapath.
- Sits directly upstream of the 8-bit enable-gated registers (instruction register, accumulator) and the program counter. It produces their per-cycle load/increment enables and the memory read/write strobes.
- Steps through an 8-phase instruction cycle. Decodes a 3-bit opcode and the ALU zero flag.

Parameters:
- none (phase count, opcode encoding and widths are fixed by the ISA)

Ports:
- clk     input   1  system clock; all state updates on posedge
- rst_    input   1  asynchronous, active-low reset; forces phase to INST_ADDR and clears halted state
- opcode  input   3  instruction-register opcode field; stable from INST_LOAD onward
- zero    input   1  accumulator-zero flag from ALU
- mem_rd  output  1  memory read strobe
- load_ir output  1  instruction register enable
- halt    output  1  processor halted indicator
- inc_pc  output  1  program counter increment enable
- load_ac output  1  accumulator enable
- load_pc output  1  program counter load enable (jump)
- mem_wr  output  1  memory write strobe

Behaviour:
- Single clock domain, clk. Reset rst_ is asynchronous and active-low.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = opcode in {ADD, AND, XOR, LDA}.
- State: 3-bit phase register plus 1-bit halted flag.
- Phase order: INST_ADDR(0) -> INST_FETCH(1) -> INST_LOAD(2) -> IDLE(3) -> OP_ADDR(4) -> OP_FETCH(5) -> ALU_OP(6) -> STORE(7) -> INST_ADDR.
- Phase advances by one each clk; it wraps from 7 to 0.
- Reset (async, any time, including mid-instruction):
  - phase=INST_ADDR, halted=0.
  - All outputs 0 while rst_ low and in the first cycle after release.
  - First increment on the first posedge with rst_ high.
- Outputs are combinational decode of (phase, opcode, zero, halted). There are no registered outputs, so enables are valid in the same cycle as the phase:
  - INST_ADDR: all 0
  - INST_FETCH: mem_rd=1
  - INST_LOAD: mem_rd=1, load_ir=1
  - IDLE: mem_rd=1, load_ir=1
  - OP_ADDR: halt=(opcode==HLT), inc_pc=(opcode!=HLT)
  - OP_FETCH: mem_rd=ALUOP
  - ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP)
  - STORE: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==JMP), load_pc=(opcode==JMP), mem_wr=(opcode==STO)
- Halt:
  - When phase==OP_ADDR and opcode==HLT at a posedge, halted sets and phase stays OP_ADDR.
  - While halted: phase frozen, halt=1, every other output 0, and opcode/zero are ignored.
  - Only rst_ exits halt.
- mem_rd and mem_wr are never 1 in the same cycle, for any opcode.
- load_pc and inc_pc are both 1 only in STORE with JMP. The PC gives load priority.
- zero is sampled only in ALU_OP; its value in other phases has no effect.
- X/Z on opcode in phases 0-3 must not affect outputs.

Test Plan:
- Reset mid-ALU_OP with opcode=ADD -> phase=0 and all outputs 0 immediately (no clock). After release, 8 clocks walk phases 0..7 with the decode above.
- opcode=LDA, zero=0 over one instruction -> mem_rd=1 in phases 1,2,3,5,6,7; load_ir=1 in 2,3; inc_pc=1 in 4; load_ac=1 in 6,7; mem_wr and load_pc never 1.
- opcode=SKZ with zero=1, then zero=0 -> inc_pc=1 in phases 4 and 6 for the first instruction; inc_pc=1 in phase 4 only for the second.
- opcode=JMP -> load_pc=1 in phases 6,7; inc_pc=1 in phases 4,7; load_ac=0 throughout.
- opcode=STO -> mem_wr=1 only in phase 7; mem_rd=0 in phases 5-7.
- opcode=HLT -> halt=1 from phase 4 onward, held for 20 clocks with phase frozen at 4 and other outputs 0 while opcode toggles. Asserting rst_=0 then releasing returns phase to 0 with halt=0.
